// File: rtl/mon_pkg.sv
// Shared types for the commit-serializing monitor: commit record, error-bit
// indices and FSM state encoding.
package mon_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] inst;
    logic        halt;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } commit_pkt_t;

  localparam int unsigned ErrOrder    = 0;
  localparam int unsigned ErrGap      = 1;
  localparam int unsigned ErrOverflow = 2;
  localparam int unsigned ErrPostHalt = 3;
  localparam int unsigned NumErr      = 4;

  typedef logic [1:0] state_t;
  localparam state_t StRun    = 2'd0;
  localparam state_t StDrain  = 2'd1;
  localparam state_t StHalted = 2'd2;

  function automatic logic [NumErr-1:0] err_vec(input logic order_err, input logic gap_err,
                                                input logic ovf_err, input logic post_err);
    logic [NumErr-1:0] v;
    v              = '0;
    v[ErrOrder]    = order_err;
    v[ErrGap]      = gap_err;
    v[ErrOverflow] = ovf_err;
    v[ErrPostHalt] = post_err;
    return v;
  endfunction

endpackage

// File: rtl/mon_commit_serializer_if.sv
// Commit-input and serialized-output handshake bundle for the monitor.
// master drives commits and consumes output; slave is the serializer.
interface mon_commit_serializer_if
  import mon_pkg::*;
#(
  parameter int unsigned NUM_CH = 2
);
  logic [NUM_CH-1:0]       ch_valid;
  commit_pkt_t [NUM_CH-1:0] ch_pkt;
  logic                    out_valid;
  logic                    out_ready;
  commit_pkt_t             out_pkt;

  modport master (
    output ch_valid,
    output ch_pkt,
    output out_ready,
    input  out_valid,
    input  out_pkt
  );

  modport slave (
    input  ch_valid,
    input  ch_pkt,
    input  out_ready,
    output out_valid,
    output out_pkt
  );
endinterface

// File: rtl/mon_multi_push_fifo.sv
// Circular FIFO accepting up to NUM_CH packets per cycle (slots 0..push_cnt-1)
// and popping one. The caller guarantees push_cnt never exceeds free space.
module mon_multi_push_fifo
  import mon_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(NUM_CH+1)-1:0]  push_cnt,
  input  commit_pkt_t [NUM_CH-1:0]     push_pkt,
  input  logic                         pop,
  output commit_pkt_t                  head_pkt,
  output logic [$clog2(DEPTH):0]       occupancy
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = $clog2(DEPTH) + 1;

  commit_pkt_t     mem_q [DEPTH];
  commit_pkt_t     mem_d [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic            do_pop;

  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (k < 32'(push_cnt)) begin
        mem_d[wptr_q + PtrW'(k)] = push_pkt[k];
      end
    end
  end

  always_comb begin
    do_pop = pop && (occ_q != '0);
    wptr_d = wptr_q + PtrW'(push_cnt);
    rptr_d = rptr_q + PtrW'(do_pop);
    occ_d  = occ_q + OccW'(push_cnt) - OccW'(do_pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  assign head_pkt  = mem_q[rptr_q];
  assign occupancy = occ_q;

endmodule

// File: rtl/mon_commit_serializer.sv
// Serializes up to NUM_CH retired commits per cycle into a single in-order
// stream, checking order continuity and stopping cleanly after a halt.
module mon_commit_serializer
  import mon_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  mon_commit_serializer_if.slave  bus,
  output logic                    halted,
  output logic                    error,
  output logic [NumErr-1:0]       err_code,
  output logic [63:0]             commit_count,
  output logic [$clog2(DEPTH):0]  occupancy
);
  localparam int unsigned CntW = $clog2(NUM_CH + 1);
  localparam int unsigned OccW = $clog2(DEPTH) + 1;

  state_t                   state_q, state_d;
  logic [NumErr-1:0]        err_q, err_d;
  logic [63:0]              expected_order_q, expected_order_d;
  logic [63:0]              commit_count_q, commit_count_d;

  commit_pkt_t [NUM_CH-1:0] push_pkt;
  logic [CntW-1:0]          push_cnt;
  commit_pkt_t              head_pkt;
  logic                     pop;
  int unsigned              free;
  int unsigned              n_push;
  int unsigned              n_valid;
  logic                     hole;
  logic                     gap_err;
  logic                     order_err;
  logic                     overflow;
  logic                     halt_seen;
  logic                     after_halt;
  logic                     idle_input;
  logic                     take_halt;
  logic                     drained;

  // Walk channels oldest-first; packets behind an accepted halt are dropped.
  always_comb begin
    pop        = bus.out_valid & bus.out_ready;
    free       = DEPTH - 32'(occupancy) + 32'(pop);
    push_pkt   = '0;
    n_push     = 0;
    n_valid    = 0;
    hole       = 1'b0;
    gap_err    = 1'b0;
    order_err  = 1'b0;
    halt_seen  = 1'b0;
    after_halt = 1'b0;
    idle_input = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!bus.ch_valid[i]) begin
        hole = 1'b1;
      end else begin
        if (hole) gap_err = 1'b1;
        if (state_q != StRun) begin
          idle_input = 1'b1;
        end else if (halt_seen) begin
          after_halt = 1'b1;
        end else begin
          if (bus.ch_pkt[i].order != expected_order_q + 64'(n_valid)) order_err = 1'b1;
          for (int k = 0; k < NUM_CH; k++) begin
            if (k == n_push) push_pkt[k] = bus.ch_pkt[i];
          end
          n_push    = n_push + 1;
          halt_seen = bus.ch_pkt[i].halt;
        end
        n_valid = n_valid + 1;
      end
    end
    overflow  = (n_push > free);
    push_cnt  = overflow ? '0 : CntW'(n_push);
    take_halt = halt_seen & ~overflow;
  end

  always_comb begin
    drained = (occupancy + OccW'(push_cnt) - OccW'(pop)) == '0;
    state_d = state_q;
    case (state_q)
      StRun:   if (take_halt) state_d = StDrain;
      StDrain: if (drained) state_d = StHalted;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    err_d            = err_q | err_vec(order_err, gap_err, overflow,
                                       idle_input | (after_halt & ~overflow));
    expected_order_d = expected_order_q + 64'(n_valid);
    commit_count_d   = commit_count_q + 64'(push_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StRun;
      err_q            <= '0;
      expected_order_q <= '0;
      commit_count_q   <= '0;
    end else begin
      state_q          <= state_d;
      err_q            <= err_d;
      expected_order_q <= expected_order_d;
      commit_count_q   <= commit_count_d;
    end
  end

  mon_multi_push_fifo #(
    .NUM_CH(NUM_CH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_cnt (push_cnt),
    .push_pkt (push_pkt),
    .pop      (pop),
    .head_pkt (head_pkt),
    .occupancy(occupancy)
  );

  assign bus.out_valid = (occupancy != '0);
  assign bus.out_pkt   = head_pkt;
  assign halted        = (state_q == StHalted);
  assign err_code      = err_q;
  assign error         = |err_q;
  assign commit_count  = commit_count_q;

endmodule
